// File: rtl/mem_arbiter.sv
// Shares one unified memory between the fetch and data ports of the pipelined core.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
//
// state  | meaning
// IDLE   | no access outstanding, arbitrating every cycle
// BUSY_D | data access on the memory bus, waiting for mem_ready
// BUSY_I | fetch access on the memory bus, waiting for mem_ready
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t     state, state_nx;
  logic [3:0] starve_cnt;
  logic       done, arb, if_pend, d_pend, grant_d, grant_i;

  // A request whose ready is pulsing is the one just served; it is not a new request.
  assign if_pend = if_req & ~if_ready & (state != BUSY_I);
  assign d_pend  = d_req  & ~d_ready  & (state != BUSY_D);
  assign done    = mem_ready & (state != IDLE);
  assign arb     = (state == IDLE) | done;

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    if (arb) begin
      state_nx = IDLE;
      if (d_pend && (!if_pend || starve_cnt != STARVE_LIM)) begin
        grant_d  = 1'b1;
        state_nx = BUSY_D;
      end else if (if_pend) begin
        grant_i  = 1'b1;
        state_nx = BUSY_I;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      state    <= state_nx;
      if_ready <= done & (state == BUSY_I);
      d_ready  <= done & (state == BUSY_D);

      if (done && state == BUSY_I)
        if_rdata <= mem_rdata;
      if (done && state == BUSY_D && !mem_we)
        d_rdata <= mem_rdata;

      if (grant_d) begin
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (if_pend)
          starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
        else
          starve_cnt <= 4'd0;
      end else if (grant_i) begin
        mem_en     <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= 32'd0;
        starve_cnt <= 4'd0;
      end else if (done) begin
        mem_en <= 1'b0;
      end
    end
  end

endmodule
